// File: rtl/fg_waveform_gen.sv
// ============================================================================
//  Module   : fg_waveform_gen
//  Brief    : Three-stage function-generator datapath (shape, gain, offset/
//             saturate). Define FG_SINE_LUT_EN to build the quarter-wave sine.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fg_waveform_gen #(
    parameter int PHASE_BITWIDTH = 10,
    parameter int OUT_BITWIDTH   = 8
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      enable_i,
    input  logic [PHASE_BITWIDTH-1:0] phase_i,
    input  logic                      phaseValid_i,
    input  logic [2:0]                waveSel_i,
    input  logic [PHASE_BITWIDTH-1:0] dutyCycle_i,
    input  logic [OUT_BITWIDTH-1:0]   amplitude_i,
    input  logic [OUT_BITWIDTH-1:0]   offset_i,
    output logic [OUT_BITWIDTH-1:0]   sample_o,
    output logic                      sampleValid_o
);

    localparam int P = PHASE_BITWIDTH;
    localparam int N = OUT_BITWIDTH;

    localparam logic [N-1:0] c_full = '1;
    localparam logic [N-1:0] c_mid  = {1'b1, {(N-1){1'b0}}};

    logic [N-1:0]   w_raw;
    logic [N-1:0]   w_sine_raw;
    logic [N:0]     w_gain;
    logic [2*N-1:0] w_prod;
    logic [N-1:0]   w_scaled;
    logic [N+1:0]   w_off_ext;
    logic [N+1:0]   w_sum;
    logic [N-1:0]   w_sat;

    logic           r_s1_valid;
    logic [N-1:0]   r_s1_raw;
    logic           r_s2_valid;
    logic [N-1:0]   r_s2_scaled;
    logic           r_out_valid;
    logic [N-1:0]   r_sample;

`ifdef FG_SINE_LUT_EN
    // round(127*sin((i+0.5)*pi/128)); first quadrant only
    function automatic logic [6:0] f_sine_lut(input logic [5:0] idx);
        logic [6:0] v;
        case (idx)
            6'd0:  v = 7'd2;    6'd1:  v = 7'd5;    6'd2:  v = 7'd8;    6'd3:  v = 7'd11;
            6'd4:  v = 7'd14;   6'd5:  v = 7'd17;   6'd6:  v = 7'd20;   6'd7:  v = 7'd23;
            6'd8:  v = 7'd26;   6'd9:  v = 7'd29;   6'd10: v = 7'd32;   6'd11: v = 7'd35;
            6'd12: v = 7'd38;   6'd13: v = 7'd41;   6'd14: v = 7'd44;   6'd15: v = 7'd47;
            6'd16: v = 7'd50;   6'd17: v = 7'd53;   6'd18: v = 7'd56;   6'd19: v = 7'd58;
            6'd20: v = 7'd61;   6'd21: v = 7'd64;   6'd22: v = 7'd67;   6'd23: v = 7'd69;
            6'd24: v = 7'd72;   6'd25: v = 7'd74;   6'd26: v = 7'd77;   6'd27: v = 7'd79;
            6'd28: v = 7'd82;   6'd29: v = 7'd84;   6'd30: v = 7'd86;   6'd31: v = 7'd89;
            6'd32: v = 7'd91;   6'd33: v = 7'd93;   6'd34: v = 7'd95;   6'd35: v = 7'd97;
            6'd36: v = 7'd99;   6'd37: v = 7'd101;  6'd38: v = 7'd103;  6'd39: v = 7'd105;
            6'd40: v = 7'd106;  6'd41: v = 7'd108;  6'd42: v = 7'd110;  6'd43: v = 7'd111;
            6'd44: v = 7'd113;  6'd45: v = 7'd114;  6'd46: v = 7'd115;  6'd47: v = 7'd117;
            6'd48: v = 7'd118;  6'd49: v = 7'd119;  6'd50: v = 7'd120;  6'd51: v = 7'd121;
            6'd52: v = 7'd122;  6'd53: v = 7'd123;  6'd54: v = 7'd124;  6'd55: v = 7'd124;
            6'd56: v = 7'd125;  6'd57: v = 7'd125;  6'd58: v = 7'd126;  6'd59: v = 7'd126;
            default: v = 7'd127;
        endcase
        return v;
    endfunction

    logic [1:0] w_quad;
    logic [5:0] w_idx;
    logic [6:0] w_mag;
    logic [7:0] w_sine8;

    // Odd quadrants walk the table backwards: 63-idx is the bitwise inverse
    assign w_quad     = phase_i[P-1 -: 2];
    assign w_idx      = w_quad[0] ? ~phase_i[P-3 -: 6] : phase_i[P-3 -: 6];
    assign w_mag      = f_sine_lut(w_idx);
    assign w_sine8    = w_quad[1] ? (8'd128 - {1'b0, w_mag}) : (8'd128 + {1'b0, w_mag});
    assign w_sine_raw = OUT_BITWIDTH'(w_sine8) << (N - 8);
`else
    assign w_sine_raw = c_mid;
`endif

    always_comb begin
        w_raw = '0;
        case (waveSel_i)
            3'd0:    w_raw = (phase_i < dutyCycle_i) ? c_full : '0;
            3'd1:    w_raw = phase_i[P-1 -: N];
            3'd2:    w_raw = phase_i[P-1] ? ~phase_i[P-2 -: N] : phase_i[P-2 -: N];
            3'd3:    w_raw = w_sine_raw;
            default: w_raw = c_full;
        endcase
    end

    // Product cannot exceed 2N bits since (2^N-1)*2^N < 2^(2N)
    assign w_gain   = {1'b0, amplitude_i} + {{N{1'b0}}, 1'b1};
    assign w_prod   = {{N{1'b0}}, r_s1_raw} * {{(N-1){1'b0}}, w_gain};
    assign w_scaled = OUT_BITWIDTH'(w_prod >> N);

    assign w_off_ext = {{2{offset_i[N-1]}}, offset_i};
    assign w_sum     = {2'b00, r_s2_scaled} + w_off_ext;

    always_comb begin
        w_sat = w_sum[N-1:0];
        if (w_sum[N+1]) begin
            w_sat = '0;
        end else if (w_sum[N]) begin
            w_sat = c_full;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_s1_valid  <= 1'b0;
            r_s1_raw    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_scaled <= '0;
            r_out_valid <= 1'b0;
            r_sample    <= '0;
        end else if (!enable_i) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_sample    <= '0;
        end else begin
            r_s1_valid  <= phaseValid_i;
            r_s2_valid  <= r_s1_valid;
            r_out_valid <= r_s2_valid;
            if (phaseValid_i) begin
                r_s1_raw <= w_raw;
            end
            if (r_s1_valid) begin
                r_s2_scaled <= w_scaled;
            end
            if (r_s2_valid) begin
                r_sample <= w_sat;
            end
        end
    end

    assign sample_o      = r_sample;
    assign sampleValid_o = r_out_valid;

endmodule

`default_nettype wire

// File: doc/fg_waveform_gen.md
FG_WAVEFORM_GEN -- requirements
Module: fg_waveform_gen

Interface
REQ-001 SHALL have parameter PHASE_BITWIDTH, default 10, phase input width; legal range 10..16.
REQ-002 SHALL have parameter OUT_BITWIDTH, default 8, sample width; legal range 8..PHASE_BITWIDTH-2.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port enable_i  input  1  0 = idle/flush, 1 = generate.
REQ-006 SHALL have port phase_i  input  PHASE_BITWIDTH  phase from upstream timer counter.
REQ-007 SHALL have port phaseValid_i  input  1  one-cycle strobe, phase_i valid (timer clock-enable).
REQ-008 SHALL have port waveSel_i  input  3  0 square, 1 sawtooth, 2 triangle, 3 sine, 4..7 DC.
REQ-009 SHALL have port dutyCycle_i  input  PHASE_BITWIDTH  square-wave high threshold.
REQ-010 SHALL have port amplitude_i  input  OUT_BITWIDTH  gain, unsigned.
REQ-011 SHALL have port offset_i  input  OUT_BITWIDTH  signed two's-complement offset.
REQ-012 SHALL have port sample_o  output  OUT_BITWIDTH  unsigned DAC code, registered.
REQ-013 SHALL have port sampleValid_o  output  1  one-cycle strobe per new sample.

Function
REQ-014 SHALL be a 3-stage pipeline (S1 shape, S2 gain, S3 offset/saturate); sampleValid_o pulses exactly 3 cycles after phaseValid_i is sampled high with enable_i high.
REQ-015 SHALL accept a phaseValid_i on every cycle (no back-pressure); back-to-back strobes produce back-to-back valids.
REQ-016 SHALL sample waveSel_i/dutyCycle_i/phase_i in S1, amplitude_i in S2, offset_i in S3; configuration changes take effect per stage, no glitch or hold logic.
REQ-017 Square: raw = 2^N-1 when phase_i < dutyCycle_i, else 0 (N = OUT_BITWIDTH, P = PHASE_BITWIDTH); dutyCycle_i = 0 gives constant 0.
REQ-018 Sawtooth: raw = phase_i[P-1 -: N].
REQ-019 Triangle: raw = phase_i[P-2 -: N] when phase_i[P-1] = 0, else bitwise inverse of phase_i[P-2 -: N].
REQ-020 Sine: quarter-wave table of 64 7-bit entries, LUT[i] = round(127*sin((i+0.5)*pi/128)); quadrant q = phase_i[P-1:P-2], idx = phase_i[P-3 -: 6]; q0 +LUT[idx], q1 +LUT[63-idx], q2 -LUT[idx], q3 -LUT[63-idx]; raw8 = 128 +/- mag; raw = raw8 << (N-8).
REQ-021 DC (waveSel 4..7): raw = 2^N-1.
REQ-022 S2: scaled = (raw * (amplitude_i + 1)) >> N, full-width product, no truncation before shift; amplitude_i = 2^N-1 is unity gain.
REQ-023 S3: sum = scaled + sign-extended offset_i computed at N+2 bits; sample_o = 0 if sum < 0, 2^N-1 if sum > 2^N-1, else sum.
REQ-024 sample_o SHALL hold its value between sampleValid_o strobes.
REQ-025 enable_i low: phaseValid_i ignored, all stage valid bits cleared on next edge, sampleValid_o = 0, sample_o = 0 on next edge; re-enable restarts with 3-cycle latency.
REQ-026 Phase wrap-around (max to 0) SHALL require no special handling; waveforms are continuous per REQ-017..021.

Reset
REQ-027 rstn_i low SHALL asynchronously clear sample_o = 0, sampleValid_o = 0, all pipeline data and valid registers = 0.
REQ-028 Reset asserted mid-operation SHALL discard in-flight samples; first valid after release requires a new phaseValid_i plus 3 cycles.

Configuration
REQ-029 Macro FG_SINE_LUT_EN defined: sine table and quadrant logic per REQ-020 are compiled in.
REQ-030 FG_SINE_LUT_EN undefined: no table is synthesised; waveSel_i = 3 yields raw = 2^(N-1) (midscale); all other selections unchanged.

Verification (P=10, N=8, amplitude 255, offset 0 unless stated)
REQ-031 Sawtooth, phase 512 strobe -> sample_o = 128 with sampleValid_o high exactly 3 cycles later, one cycle only.
REQ-032 Square, duty 256: phase 255 -> 255; phase 256 -> 0; duty 0, any phase -> 0.
REQ-033 Triangle: phase 256 -> 128; phase 768 -> 127; phase 1023 -> 0.
REQ-034 Sawtooth phase 1020 (raw 255): amplitude 127 -> 127; amplitude 127 + offset +100 -> 227; amplitude 255 + offset +127 -> 255 (saturate); raw 0 with offset -128 -> 0.
REQ-035 Sine with FG_SINE_LUT_EN: phase 0 -> 130, phase 256 -> 255, phase 768 -> 1; without macro, phase 0 -> 128.
REQ-036 Strobes on 3 consecutive cycles, then enable_i low or rstn_i low mid-pipeline -> no further sampleValid_o, sample_o = 0.
